// File: rtl/noc_pkg.sv
// Shared NoC types: header layout, field widths, packetizer FSM states.
// Latency: n/a (types only). Backpressure: n/a.
package noc_pkg;
    localparam int NOC_DATA_W    = 32;
    localparam int NOC_ROUTERS_X = 4;
    localparam int NOC_ROUTERS_Y = 4;
    localparam int NOC_MAX_PKG   = 5;

    localparam int NOC_X_W   = $clog2(NOC_ROUTERS_X);
    localparam int NOC_Y_W   = $clog2(NOC_ROUTERS_Y);
    localparam int NOC_LEN_W = $clog2(NOC_MAX_PKG);
    localparam int NOC_PAD_W = NOC_DATA_W - 2 * NOC_X_W - 2 * NOC_Y_W - NOC_LEN_W;

    // Field order is LSB-first from dest_x upward; the router decodes dest_* only.
    typedef struct packed {
        logic [NOC_PAD_W-1:0] pad;
        logic [NOC_LEN_W-1:0] len;
        logic [NOC_Y_W-1:0]   src_y;
        logic [NOC_X_W-1:0]   src_x;
        logic [NOC_Y_W-1:0]   dest_y;
        logic [NOC_X_W-1:0]   dest_x;
    } noc_header_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        BODY = 2'd2
    } pkt_state_t;

    function automatic noc_header_t pack_header(
        input logic [NOC_X_W-1:0]   dest_x,
        input logic [NOC_Y_W-1:0]   dest_y,
        input logic [NOC_X_W-1:0]   src_x,
        input logic [NOC_Y_W-1:0]   src_y,
        input logic [NOC_LEN_W-1:0] len
    );
        noc_header_t h;
        h.pad    = '0;
        h.len    = len;
        h.src_y  = src_y;
        h.src_x  = src_x;
        h.dest_y = dest_y;
        h.dest_x = dest_x;
        return h;
    endfunction
endpackage

// File: rtl/noc_packetizer.sv
// Command + payload stream -> one NoC packet (header, body, TLAST). NOC_PKT_CNT_EN adds pkt_count.
// Latency: header valid 2 cycles after cmd accept; body flit 1 cycle after its s-beat.
// Backpressure: single output register; m_tready low stalls FSM and s_tready, outputs held.
module noc_packetizer
    import noc_pkg::*;
#(
    parameter int DATA_WIDTH              = NOC_DATA_W,
    parameter int MAX_ROUTERS_X           = NOC_ROUTERS_X,
    parameter int MAX_ROUTERS_Y           = NOC_ROUTERS_Y,
    parameter int ROUTER_X                = 0,
    parameter int ROUTER_Y                = 0,
    parameter int MAXIMUM_PACKAGES_NUMBER = NOC_MAX_PKG,
    localparam int X_W   = $clog2(MAX_ROUTERS_X),
    localparam int Y_W   = $clog2(MAX_ROUTERS_Y),
    localparam int LEN_W = $clog2(MAXIMUM_PACKAGES_NUMBER)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [X_W-1:0]        cmd_dest_x,
    input  logic [Y_W-1:0]        cmd_dest_y,
    input  logic [LEN_W-1:0]      cmd_len,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tlast
`ifdef NOC_PKT_CNT_EN
    ,
    output logic [15:0]           pkt_count
`endif
);
    localparam logic [LEN_W-1:0] MAX_BODY = LEN_W'(MAXIMUM_PACKAGES_NUMBER - 1);

    pkt_state_t            state_q, state_d;
    logic [LEN_W-1:0]      cnt_q, cnt_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [X_W-1:0]        dest_x_q, dest_x_d;
    logic [Y_W-1:0]        dest_y_q, dest_y_d;
    logic [DATA_WIDTH-1:0] m_tdata_q, m_tdata_d;
    logic                  m_tvalid_q, m_tvalid_d;
    logic                  m_tlast_q, m_tlast_d;
    logic                  ld;
    logic [LEN_W-1:0]      eff_len;
    noc_header_t           hdr;

    assign ld      = !m_tvalid_q || m_tready;
    assign eff_len = (cmd_len > MAX_BODY) ? MAX_BODY : cmd_len;
    assign hdr     = pack_header(NOC_X_W'(dest_x_q), NOC_Y_W'(dest_y_q),
                                 NOC_X_W'(ROUTER_X), NOC_Y_W'(ROUTER_Y), NOC_LEN_W'(len_q));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        dest_x_d   = dest_x_q;
        dest_y_d   = dest_y_q;
        m_tdata_d  = m_tdata_q;
        m_tvalid_d = m_tvalid_q;
        m_tlast_d  = m_tlast_q;
        cmd_ready  = 1'b0;
        s_tready   = 1'b0;
        if (ld) begin
            m_tvalid_d = 1'b0;
        end
        case (state_q)
            IDLE: begin
                cmd_ready = !rst;
                if (cmd_valid) begin
                    dest_x_d = cmd_dest_x;
                    dest_y_d = cmd_dest_y;
                    len_d    = eff_len;
                    cnt_d    = eff_len;
                    state_d  = HDR;
                end
            end
            HDR: begin
                if (ld) begin
                    m_tdata_d  = DATA_WIDTH'(hdr);
                    m_tvalid_d = 1'b1;
                    m_tlast_d  = (len_q == '0);
                    state_d    = (len_q != '0) ? BODY : IDLE;
                end
            end
            BODY: begin
                s_tready = ld && !rst;
                if (s_tvalid && ld) begin
                    m_tdata_d  = s_tdata;
                    m_tvalid_d = 1'b1;
                    m_tlast_d  = (cnt_q == LEN_W'(1));
                    cnt_d      = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            len_q      <= '0;
            dest_x_q   <= '0;
            dest_y_q   <= '0;
            m_tdata_q  <= '0;
            m_tvalid_q <= 1'b0;
            m_tlast_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            dest_x_q   <= dest_x_d;
            dest_y_q   <= dest_y_d;
            m_tdata_q  <= m_tdata_d;
            m_tvalid_q <= m_tvalid_d;
            m_tlast_q  <= m_tlast_d;
        end
    end

    assign m_tdata  = m_tdata_q;
    assign m_tvalid = m_tvalid_q;
    assign m_tlast  = m_tlast_q;

`ifdef NOC_PKT_CNT_EN
    logic [15:0] pkt_count_q, pkt_count_d;

    // Counts packets delivered to the router, wrapping naturally at 16 bits.
    assign pkt_count_d = (m_tvalid_q && m_tready && m_tlast_q) ? pkt_count_q + 16'd1 : pkt_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_count_q <= '0;
        end else begin
            pkt_count_q <= pkt_count_d;
        end
    end

    assign pkt_count = pkt_count_q;
`endif
endmodule

// File: tb/tb_noc_packetizer.sv
// Randomized bench for noc_packetizer against a flit-queue reference model.
module tb_noc_packetizer;
    localparam int DW   = 32;
    localparam int RX   = 1;
    localparam int RY   = 3;
    localparam int MAXP = 5;
    localparam int XW   = $clog2(4);
    localparam int YW   = $clog2(4);
    localparam int LW   = $clog2(MAXP);

    logic          clk;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [XW-1:0] cmd_dest_x;
    logic [YW-1:0] cmd_dest_y;
    logic [LW-1:0] cmd_len;
    logic [DW-1:0] s_tdata = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready = 1'b1;
    logic          m_tlast;
`ifdef NOC_PKT_CNT_EN
    logic [15:0]   pkt_count;
`endif

    noc_packetizer #(
        .DATA_WIDTH(DW), .MAX_ROUTERS_X(4), .MAX_ROUTERS_Y(4),
        .ROUTER_X(RX), .ROUTER_Y(RY), .MAXIMUM_PACKAGES_NUMBER(MAXP)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_dest_x(cmd_dest_x), .cmd_dest_y(cmd_dest_y), .cmd_len(cmd_len),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast)
`ifdef NOC_PKT_CNT_EN
        , .pkt_count(pkt_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            n_err = 0;
    int            n_chk = 0;
    logic [DW-1:0] exp_q[$];
    logic          expl_q[$];
    logic [DW-1:0] pay_q[$];
    int            rdy_mode = 0;
    int            s_beats = 0;
    int            s_rdy_cnt = 0;
    int            out_cnt = 0;
    bit            prev_stall = 0;
    logic [DW-1:0] prev_dat;
    logic          prev_last;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Sink readiness and payload source, updated just after each rising edge.
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       m_tready = 1'b1;
            1:       m_tready = 1'($urandom_range(0, 1));
            default: m_tready = 1'b0;
        endcase
        s_tvalid = (pay_q.size() > 0) && ($urandom_range(0, 3) != 0);
        s_tdata  = (pay_q.size() > 0) ? pay_q[0] : '0;
    end

    // Handshakes are observed mid-cycle; they complete on the next rising edge.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                chk("stall_vld", 64'(m_tvalid), 64'd1);
                chk("stall_dat", 64'(m_tdata), 64'(prev_dat));
                chk("stall_last", 64'(m_tlast), 64'(prev_last));
            end
            if (s_tready) s_rdy_cnt++;
            if (s_tvalid && s_tready) begin
                if (pay_q.size() > 0) void'(pay_q.pop_front());
                s_beats++;
            end
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_flit", 64'(m_tdata), 64'hdead);
                end else begin
                    chk("flit_dat", 64'(m_tdata), 64'(exp_q[0]));
                    chk("flit_last", 64'(m_tlast), 64'(expl_q[0]));
                    void'(exp_q.pop_front());
                    void'(expl_q.pop_front());
                end
                out_cnt++;
            end
            prev_stall = m_tvalid && !m_tready;
            prev_dat   = m_tdata;
            prev_last  = m_tlast;
        end
    end

    task automatic model_pkt(input int dx, input int dy, input int len, input int extra, input bit seq);
        int            eff;
        logic [DW-1:0] w;
        eff = (len > MAXP - 1) ? MAXP - 1 : len;
        w = DW'(dx) | (DW'(dy) << XW) | (DW'(RX) << (XW + YW)) |
            (DW'(RY) << (2 * XW + YW)) | (DW'(eff) << (2 * XW + 2 * YW));
        exp_q.push_back(w);
        expl_q.push_back(eff == 0);
        for (int i = 0; i < eff; i++) begin
            w = seq ? DW'(32'hA + i) : DW'($urandom);
            exp_q.push_back(w);
            expl_q.push_back(i == eff - 1);
            pay_q.push_back(w);
        end
        for (int i = 0; i < extra; i++) pay_q.push_back(DW'($urandom));
    endtask

    task automatic issue_cmd(input int dx, input int dy, input int len);
        int n;
        @(posedge clk);
        #2;
        cmd_valid  = 1'b1;
        cmd_dest_x = XW'(dx);
        cmd_dest_y = YW'(dy);
        cmd_len    = LW'(len);
        for (n = 0; n < 100; n++) begin
            @(negedge clk);
            if (cmd_ready) break;
        end
        if (n == 100) chk("cmd_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #2;
        cmd_valid  = 1'b0;
        cmd_dest_x = XW'($urandom);
        cmd_dest_y = YW'($urandom);
        cmd_len    = LW'($urandom);
    endtask

    task automatic send_pkt(input int dx, input int dy, input int len, input int extra, input bit seq);
        int b0, r0, eff, n;
        eff = (len > MAXP - 1) ? MAXP - 1 : len;
        b0  = s_beats;
        r0  = s_rdy_cnt;
        model_pkt(dx, dy, len, extra, seq);
        issue_cmd(dx, dy, len);
        for (n = 0; n < 400; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        if (n == 400) chk("pkt_timeout", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
        chk("body_beats", 64'(s_beats - b0), 64'(eff));
        chk("unconsumed", 64'(pay_q.size()), 64'(extra));
        if (len == 0) chk("s_tready_len0", 64'(s_rdy_cnt - r0), 64'd0);
        pay_q.delete();
    endtask

    initial begin
        int n, o0;
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_dest_x = '0;
        cmd_dest_y = '0;
        cmd_len = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_m_tlast", 64'(m_tlast), 64'd0);
        chk("rst_m_tdata", 64'(m_tdata), 64'd0);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("rst_s_tready", 64'(s_tready), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);

        send_pkt(2, 1, 3, 0, 1'b1);
        send_pkt(1, 2, 0, 1, 1'b0);
        send_pkt(3, 3, 7, 1, 1'b0);
        rdy_mode = 1;
        send_pkt(0, 1, 4, 0, 1'b1);
        send_pkt(2, 3, 4, 1, 1'b0);

        // Reset while the second body flit sits stalled in the output register.
        rdy_mode = 0;
        o0 = out_cnt;
        model_pkt(1, 1, 4, 0, 1'b0);
        issue_cmd(1, 1, 4);
        for (n = 0; n < 200 && out_cnt < o0 + 2; n++) @(negedge clk);
        rdy_mode = 2;
        for (n = 0; n < 200; n++) begin
            @(negedge clk);
            if (m_tvalid && !m_tready) break;
        end
        chk("stalled_2nd_body", 64'(m_tdata), 64'(exp_q[0]));
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("midrst_cmd_ready", 64'(cmd_ready), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        expl_q.delete();
        pay_q.delete();
        @(negedge clk);
        chk("midrst_m_tvalid", 64'(m_tvalid), 64'd0);
        chk("midrst_m_tlast", 64'(m_tlast), 64'd0);
        chk("midrst_cmd_ready_after", 64'(cmd_ready), 64'd1);
        rdy_mode = 0;
        send_pkt(3, 2, 2, 0, 1'b0);

        for (int i = 0; i < 25; i++) begin
            rdy_mode = int'($urandom_range(0, 1));
            send_pkt(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 7)), int'($urandom_range(0, 1)), 1'b0);
        end
        rdy_mode = 0;

`ifdef NOC_PKT_CNT_EN
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("cnt_rst", 64'(pkt_count), 64'd0);
        send_pkt(1, 0, 0, 0, 1'b0);
        send_pkt(2, 1, 2, 0, 1'b0);
        send_pkt(3, 2, 4, 0, 1'b0);
        chk("cnt_three", 64'(pkt_count), 64'd3);
        @(posedge clk);
        #1 force dut.pkt_count_q = 16'hFFFF;
        @(posedge clk);
        #1 release dut.pkt_count_q;
        send_pkt(0, 3, 1, 0, 1'b0);
        chk("cnt_wrap", 64'(pkt_count), 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
